// File: rtl/spi_register_bridge_if.sv
// ============================================================================
// Module      : spi_register_bridge_if
// Description : Byte-stream and local register bus bundle for the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_register_bridge_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  CS_i;
  logic [7:0]            DataReceived_i;
  logic                  Done_i;
  logic [7:0]            DataToSend_o;
  logic [ADDR_WIDTH-1:0] Address_o;
  logic [7:0]            WriteData_o;
  logic                  WriteEnable_o;
  logic                  ReadEnable_o;
  logic [7:0]            ReadData_i;

  modport slave (
    input  CS_i, DataReceived_i, Done_i, ReadData_i,
    output DataToSend_o, Address_o, WriteData_o, WriteEnable_o, ReadEnable_o
  );

  modport master (
    output CS_i, DataReceived_i, Done_i, ReadData_i,
    input  DataToSend_o, Address_o, WriteData_o, WriteEnable_o, ReadEnable_o
  );
endinterface

`default_nettype wire

// File: rtl/spi_register_bridge.sv
// ============================================================================
// Module      : spi_register_bridge
// Description : Turns SPI frames (command + data bytes) into register accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_register_bridge #(
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic              Clock,
  input  wire logic              Reset,
  spi_register_bridge_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMAND = 2'd1,
    ST_WRITE   = 2'd2,
    ST_READ    = 2'd3
  } state_t;

  state_t                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] ptr_q,     ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [7:0]            wdata_q,   wdata_d;
  logic [7:0]            dts_q,     dts_d;
  logic                  wen_q,     wen_d;
  logic                  ren_q,     ren_d;
  logic                  latch_q,   latch_d;
  logic                  cs_seen_q, cs_seen_d;

  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_is_write;
  logic                  unused_rx_bits;

  assign cmd_addr       = bus.DataReceived_i[ADDR_WIDTH-1:0];
  assign cmd_is_write   = bus.DataReceived_i[7];
  assign unused_rx_bits = ^bus.DataReceived_i;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dts_d     = dts_q;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    latch_d   = 1'b0;
    cs_seen_d = cs_seen_q | bus.CS_i;

    // A deasserted chip select overrides everything, including a same-cycle Done_i.
    if (bus.CS_i) begin
      state_d = ST_IDLE;
      dts_d   = 8'h00;
    end else begin
      if (wen_q) begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
      end
      if (latch_q) begin
        dts_d = bus.ReadData_i;
      end
      latch_d = ren_q;

      case (state_q)
        ST_IDLE: begin
          // After a reset a frame starts only once CS has been observed high.
          if (cs_seen_q) begin
            state_d = ST_COMMAND;
          end
        end
        ST_COMMAND: begin
          if (bus.Done_i) begin
            ptr_d = cmd_addr;
            if (cmd_is_write) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
              ren_d   = 1'b1;
              addr_d  = cmd_addr;
            end
          end
        end
        ST_WRITE: begin
          if (bus.Done_i) begin
            wen_d   = 1'b1;
            addr_d  = ptr_q;
            wdata_d = bus.DataReceived_i;
          end
        end
        ST_READ: begin
          if (bus.Done_i) begin
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            addr_d = ptr_q + ADDR_WIDTH'(1);
            ren_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      dts_q     <= 8'h00;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      latch_q   <= 1'b0;
      cs_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dts_q     <= dts_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      latch_q   <= latch_d;
      cs_seen_q <= cs_seen_d;
    end
  end

  assign bus.DataToSend_o  = dts_q;
  assign bus.Address_o     = addr_q;
  assign bus.WriteData_o   = wdata_q;
  assign bus.WriteEnable_o = wen_q;
  assign bus.ReadEnable_o  = ren_q;

endmodule

`default_nettype wire
